// File: rtl/disp_scan_decoder.sv
// disp_scan_decoder: loopback monitor for the multiplexed 8-digit 7-segment bus.
// It debounces digit dwells, decodes CAT back to hex, and publishes full frames. DISP_DP_EN adds decimal-point tracking.
`default_nettype none

module disp_scan_decoder #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [6:0]  cat_i,
    input  logic [7:0]  an_i,
`ifdef DISP_DP_EN
    input  logic        dp_i,
    output logic [7:0]  dp_out_o,
`endif
    output logic [31:0] hex_out_o,
    output logic [7:0]  off_out_o,
    output logic        frame_vld_o,
    output logic        seg_err_o,
    output logic        an_err_o
);

    localparam logic [7:0] C_STABLE = 8'(STABLE_CYC);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      s_cat_q;
    logic [7:0]      s_an_q;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0][3:0] stage_hex_q, stage_hex_d;
    logic [7:0]      stage_off_q, stage_off_d;
    logic [7:0]      seen_q, seen_d;
    logic [31:0]     hex_out_q;
    logic [7:0]      off_out_q;
    logic            frame_vld_q, seg_err_q, an_err_q;

    logic            w_changed, w_accept, w_onehot, w_record, w_complete;
    logic [7:0]      w_an_low;
    logic [2:0]      w_idx;
    logic [5:0]      w_dec;

`ifdef DISP_DP_EN
    logic            s_dp_q;
    logic [7:0]      stage_dp_q, stage_dp_d;
    logic [7:0]      dp_out_q;
    assign w_changed = {dp_i, an_i, cat_i} != {s_dp_q, s_an_q, s_cat_q};
    assign dp_out_o  = dp_out_q;
`else
    assign w_changed = {an_i, cat_i} != {s_an_q, s_cat_q};
`endif

    // Result is {valid, blank, nibble}; all-dark counts as a valid blank digit.
    function automatic logic [5:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40: return {2'b10, 4'h0};
            7'h79: return {2'b10, 4'h1};
            7'h24: return {2'b10, 4'h2};
            7'h30: return {2'b10, 4'h3};
            7'h19: return {2'b10, 4'h4};
            7'h12: return {2'b10, 4'h5};
            7'h02: return {2'b10, 4'h6};
            7'h78: return {2'b10, 4'h7};
            7'h00: return {2'b10, 4'h8};
            7'h10: return {2'b10, 4'h9};
            7'h08: return {2'b10, 4'hA};
            7'h03: return {2'b10, 4'hB};
            7'h46: return {2'b10, 4'hC};
            7'h21: return {2'b10, 4'hD};
            7'h06: return {2'b10, 4'hE};
            7'h0E: return {2'b10, 4'hF};
            7'h7F: return {2'b11, 4'h0};
            default: return 6'b00_0000;
        endcase
    endfunction

    always_comb begin
        cnt_d = w_changed ? 8'd1 : ((cnt_q == C_STABLE) ? cnt_q : cnt_q + 8'd1);
        // Accept once per dwell: the cycle the held sample reaches the threshold.
        w_accept = !w_changed && (cnt_q != C_STABLE) && (cnt_q + 8'd1 == C_STABLE);

        w_an_low = ~s_an_q;
        w_onehot = (w_an_low != 8'd0) && ((w_an_low & (w_an_low - 8'd1)) == 8'd0);
        w_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_an_low[i]) w_idx = 3'(i);
        end
        w_dec    = seg_decode(s_cat_q);
        w_record = w_accept && w_onehot && w_dec[5];

        stage_hex_d = stage_hex_q;
        stage_off_d = stage_off_q;
        seen_d      = (state_q == IDLE) ? 8'd0 : seen_q;
`ifdef DISP_DP_EN
        stage_dp_d  = stage_dp_q;
`endif
        if (w_record) begin
            stage_hex_d[w_idx] = w_dec[3:0];
            stage_off_d[w_idx] = w_dec[4];
            seen_d[w_idx]      = 1'b1;
`ifdef DISP_DP_EN
            stage_dp_d[w_idx]  = ~s_dp_q;
`endif
        end
        w_complete = w_record && (seen_d == 8'hFF);
        if (w_complete) seen_d = 8'd0;
        state_d = (seen_d == 8'd0) ? IDLE : COLLECT;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            s_cat_q     <= 7'h7F;
            s_an_q      <= 8'hFF;
            cnt_q       <= 8'd0;
            stage_hex_q <= '0;
            stage_off_q <= 8'hFF;
            seen_q      <= 8'd0;
            hex_out_q   <= 32'd0;
            off_out_q   <= 8'hFF;
            frame_vld_q <= 1'b0;
            seg_err_q   <= 1'b0;
            an_err_q    <= 1'b0;
`ifdef DISP_DP_EN
            s_dp_q      <= 1'b1;
            stage_dp_q  <= 8'h00;
            dp_out_q    <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            s_cat_q     <= cat_i;
            s_an_q      <= an_i;
            cnt_q       <= cnt_d;
            stage_hex_q <= stage_hex_d;
            stage_off_q <= stage_off_d;
            seen_q      <= seen_d;
            frame_vld_q <= w_complete;
            seg_err_q   <= w_accept && w_onehot && !w_dec[5];
            an_err_q    <= w_accept && !w_onehot && (s_an_q != 8'hFF);
            if (w_complete) begin
                hex_out_q <= stage_hex_d;
                off_out_q <= stage_off_d;
            end
`ifdef DISP_DP_EN
            s_dp_q      <= dp_i;
            stage_dp_q  <= stage_dp_d;
            if (w_complete) dp_out_q <= stage_dp_d;
`endif
        end
    end

    assign hex_out_o   = hex_out_q;
    assign off_out_o   = off_out_q;
    assign frame_vld_o = frame_vld_q;
    assign seg_err_o   = seg_err_q;
    assign an_err_o    = an_err_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_decoder.sv
// tb_disp_scan_decoder: directed scans checked every cycle against a dwell-level reference model,
// plus literal frame/error expectations.
`default_nettype none

module tb_disp_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  cat;
    logic [7:0]  an;
    logic [31:0] hex_out;
    logic [7:0]  off_out;
    logic        frame_vld, seg_err, an_err;
`ifdef DISP_DP_EN
    logic [7:0]  dp_out;
`endif

    disp_scan_decoder #(.STABLE_CYC(STABLE)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cat_i       (cat),
        .an_i        (an),
`ifdef DISP_DP_EN
        .dp_i        (1'b1),
        .dp_out_o    (dp_out),
`endif
        .hex_out_o   (hex_out),
        .off_out_o   (off_out),
        .frame_vld_o (frame_vld),
        .seg_err_o   (seg_err),
        .an_err_o    (an_err)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_fail   = 0;
    int n_frames = 0, n_seg_err = 0, n_an_err = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a dwell is accepted on its STABLE-th consecutive identical sample.
    logic [14:0] m_prev;
    int          m_run;
    logic [3:0]  m_hex [8];
    logic [7:0]  m_off, m_seen, m_off_out;
    logic [31:0] m_hex_out;
    logic        m_fv, m_se, m_ae;

    always @(posedge clk) begin
        int  idx;
        bit  found;
        m_fv = 1'b0; m_se = 1'b0; m_ae = 1'b0;
        if (!rst_n) begin
            m_prev = {8'hFF, 7'h7F};
            m_run  = 0;
            for (int i = 0; i < 8; i++) m_hex[i] = 4'h0;
            m_off = 8'hFF; m_seen = 8'h00; m_off_out = 8'hFF; m_hex_out = 32'h0;
        end else begin
            if ({an, cat} == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else m_run = 1;
            m_prev = {an, cat};
            if (m_run == STABLE && an != 8'hFF) begin
                if ($countones(~an) != 1) m_ae = 1'b1;
                else begin
                    idx = 0;
                    for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
                    found = 1'b0;
                    for (int v = 0; v < 16; v++) begin
                        if (seg_tab[v] == cat) begin
                            m_hex[idx] = 4'(v); m_off[idx] = 1'b0; found = 1'b1;
                        end
                    end
                    if (!found && cat == 7'h7F) begin
                        m_hex[idx] = 4'h0; m_off[idx] = 1'b1; found = 1'b1;
                    end
                    if (!found) m_se = 1'b1;
                    else begin
                        m_seen[idx] = 1'b1;
                        if (m_seen == 8'hFF) begin
                            for (int i = 0; i < 8; i++) m_hex_out[4*i +: 4] = m_hex[i];
                            m_off_out = m_off;
                            m_fv      = 1'b1;
                            m_seen    = 8'h00;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hex_out",   hex_out,         m_hex_out);
            check("off_out",   {24'd0, off_out}, {24'd0, m_off_out});
            check("frame_vld", {31'd0, frame_vld}, {31'd0, m_fv});
            check("seg_err",   {31'd0, seg_err}, {31'd0, m_se});
            check("an_err",    {31'd0, an_err},  {31'd0, m_ae});
            if (frame_vld === 1'b1) n_frames++;
            if (seg_err === 1'b1)   n_seg_err++;
            if (an_err === 1'b1)    n_an_err++;
        end
    end

    task automatic hold(input logic [7:0] a, input logic [6:0] c, input int n);
        an = a; cat = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int d, input logic [6:0] c, input bit glitch);
        hold(~(8'd1 << d), c, 8);
        if (glitch) hold(8'h00, 7'h55, 2);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; an = 8'hFF; cat = 7'h7F;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset hex", hex_out, 32'h0);
        check("reset off", {24'd0, off_out}, 32'hFF);
        check("reset vld", {31'd0, frame_vld}, 32'h0);
        rst_n = 1'b1;

        // Digits 1..8 on positions 0..7
        for (int i = 0; i < 8; i++) digit(i, seg_tab[i+1], 1'b0);
        hold(8'hFF, 7'h7F, 6);
        check("s1 frames", n_frames, 1);
        check("s1 hex", hex_out, 32'h87654321);
        check("s1 off", {24'd0, off_out}, 32'h00);

        // Digits 6,7 blank
        for (int i = 0; i < 8; i++) digit(i, (i >= 6) ? 7'h7F : seg_tab[i+1], 1'b0);
        hold(8'hFF, 7'h7F, 6);
        check("s2 frames", n_frames, 2);
        check("s2 hex", hex_out, 32'h00654321);
        check("s2 off", {24'd0, off_out}, 32'hC0);

        // Short ghost dwells between digits
        for (int i = 0; i < 8; i++) digit(i, seg_tab[i+1], 1'b1);
        hold(8'hFF, 7'h7F, 6);
        check("s3 frames", n_frames, 3);
        check("s3 hex", hex_out, 32'h87654321);
        check("s3 off", {24'd0, off_out}, 32'h00);
        check("s3 errs", n_seg_err + n_an_err, 0);

        // Undecodable digit 3 blocks the frame until resent
        for (int i = 0; i < 8; i++) digit(i, (i == 3) ? 7'h55 : seg_tab[i+1], 1'b0);
        hold(8'hFF, 7'h7F, 6);
        check("s4 seg_err", n_seg_err, 1);
        check("s4 no frame", n_frames, 3);
        digit(3, seg_tab[4], 1'b0);
        hold(8'hFF, 7'h7F, 2);
        check("s4 frames", n_frames, 4);
        check("s4 hex", hex_out, 32'h87654321);

        // Illegal anode pattern, then long idle
        hold(8'hFC, 7'h40, 8);
        check("s5 an_err", n_an_err, 1);
        hold(8'hFF, 7'h7F, 100);
        check("s5 an_err idle", n_an_err, 1);
        check("s5 frames", n_frames, 4);
        check("s5 hex", hex_out, 32'h87654321);

        // Reset mid-frame discards partial frame
        for (int i = 0; i < 5; i++) digit(i, seg_tab[(i+5) % 16], 1'b0);
        pulse_reset();
        check("s6 reset hex", hex_out, 32'h0);
        check("s6 reset off", {24'd0, off_out}, 32'hFF);
        for (int i = 0; i < 7; i++) digit(i, seg_tab[(i+9) % 16], 1'b0);
        check("s6 no early frame", n_frames, 4);
        digit(7, seg_tab[0], 1'b0);
        hold(8'hFF, 7'h7F, 4);
        check("s6 frames", n_frames, 5);
        check("s6 hex", hex_out, 32'h0FEDCBA9);
        check("s6 off", {24'd0, off_out}, 32'h00);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
